// File: rtl/dotproduct_pkg.sv
// Shared constants and FSM encoding for the dot-product serializer and the
// dot-product stage that consumes its serial stream.
package dotproduct_pkg;

   localparam int unsigned ELEM_W     = 8;
   localparam int unsigned N_ELEM     = 8;
   localparam int unsigned FRAME_BITS = 2 * N_ELEM * ELEM_W;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      SHIFT     = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/dotproduct_serializer_if.sv
// Load/serial handshake bundle between a vector producer and the serializer.
interface dotproduct_serializer_if #(
   parameter int unsigned ELEM_W = dotproduct_pkg::ELEM_W,
   parameter int unsigned N_ELEM = dotproduct_pkg::N_ELEM
);
   logic [N_ELEM*ELEM_W-1:0] AData;
   logic [N_ELEM*ELEM_W-1:0] BData;
   logic                     LoadValid;
   logic                     LoadReady;
   logic                     Start;
   logic                     SerialData;
   logic                     Done;
   logic                     Busy;

   modport master (
      output AData, BData, LoadValid, Done,
      input  LoadReady, Start, SerialData, Busy
   );

   modport slave (
      input  AData, BData, LoadValid, Done,
      output LoadReady, Start, SerialData, Busy
   );
endinterface

// File: rtl/dotproduct_serializer_piso.sv
// Parallel-in serial-out frame register; bit 0 is the next bit to transmit.
module piso_shift_reg #(
   parameter int unsigned W = dotproduct_pkg::FRAME_BITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift_en,
   input  logic [W-1:0] din,
   output logic         lsb
);
   logic [W-1:0] q;

   // A load always wins over a shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift_en) begin
         q <= {1'b0, q[W-1:1]};
      end
   end

   assign lsb = q[0];
endmodule

// File: rtl/dotproduct_serializer.sv
// Captures A/B vectors, interleaves them into a frame and streams it LSB first
// behind a one-cycle Start pulse, then holds until the consumer signals Done.
module dotproduct_serializer #(
   parameter int unsigned ELEM_W = dotproduct_pkg::ELEM_W,
   parameter int unsigned N_ELEM = dotproduct_pkg::N_ELEM
) (
   input  logic                    clk,
   input  logic                    Reset,
   dotproduct_serializer_if.slave  bus
);
   import dotproduct_pkg::*;

   localparam int unsigned VEC_W   = N_ELEM * ELEM_W;
   localparam int unsigned FRAME_W = 2 * VEC_W;
   localparam int unsigned BIT_W   = $clog2(FRAME_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

   state_t             state, state_n;
   logic [BIT_W-1:0]   cnt, cnt_n;
   logic               load;
   logic               shift_en;
   logic               frame_lsb;
   logic [FRAME_W-1:0] frame_in;
   logic               start_q, serial_q, busy_q, ready_q;

   // Element i of A lands at the bottom of its 2*ELEM_W slot, B_i right above.
   always_comb begin
      frame_in = '0;
      for (int unsigned i = 0; i < N_ELEM; i++) begin
         frame_in[2*ELEM_W*i +: ELEM_W]        = bus.AData[ELEM_W*i +: ELEM_W];
         frame_in[2*ELEM_W*i + ELEM_W +: ELEM_W] = bus.BData[ELEM_W*i +: ELEM_W];
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.LoadValid) begin
               load    = 1'b1;
               state_n = START;
            end
         end
         START: state_n = SHIFT;
         SHIFT: begin
            if (cnt == LAST_BIT) begin
               cnt_n   = '0;
               state_n = WAIT_DONE;
            end else begin
               cnt_n = cnt + BIT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (bus.Done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // The output flop presents frame bit k in SHIFT cycle k, so the register
      // advances on every edge that leads into a SHIFT cycle.
      shift_en = (state_n == SHIFT);
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         start_q  <= 1'b0;
         serial_q <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         start_q  <= (state_n == START);
         serial_q <= shift_en & frame_lsb;
         busy_q   <= (state_n != IDLE);
         ready_q  <= (state_n == IDLE);
      end
   end

   piso_shift_reg #(.W(FRAME_W)) u_frame (
      .clk      (clk),
      .rst      (Reset),
      .load     (load),
      .shift_en (shift_en),
      .din      (frame_in),
      .lsb      (frame_lsb)
   );

   assign bus.Start      = start_q;
   assign bus.SerialData = serial_q;
   assign bus.Busy       = busy_q;
   assign bus.LoadReady  = ready_q;
endmodule

// File: tb/tb_dotproduct_serializer.sv
// Scenario bench for dotproduct_serializer: directed and random frames checked
// against an arithmetic model of the frame and of the downstream dot product.
module tb_dotproduct_serializer;
   logic clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   dotproduct_serializer_if #(.ELEM_W(8), .N_ELEM(8)) bus ();

   dotproduct_serializer #(.ELEM_W(8), .N_ELEM(8)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Frame as a number: sum of A_i * 2^(16i) + B_i * 2^(16i+8).
   function automatic logic [127:0] model_stream(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         s = s + (128'(a[8*i +: 8]) << (16*i)) + (128'(b[8*i +: 8]) << (16*i + 8));
      end
      return s;
   endfunction

   function automatic int model_dot(input logic [63:0] a, input logic [63:0] b);
      int sum;
      sum = 0;
      for (int i = 0; i < 8; i++) sum += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
      return sum;
   endfunction

   // What a dot-product consumer would compute from the received stream.
   function automatic int rx_dot(input logic [127:0] rx);
      int sum;
      sum = 0;
      for (int i = 0; i < 8; i++) sum += int'(rx[16*i +: 8]) * int'(rx[16*i + 8 +: 8]);
      return sum;
   endfunction

   task automatic run_frame(input logic [63:0] a, input logic [63:0] b,
                            input int glitch_k, input int done_k,
                            input bit preloaded, input bit chain,
                            input logic [63:0] na, input logic [63:0] nb,
                            output logic [127:0] rx);
      logic [127:0] exp_s;
      bit bad;
      exp_s = model_stream(a, b);
      if (!preloaded) begin
         checks++;
         if (bus.LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: got %b want 1", bus.LoadReady);
         end
         bus.AData = a; bus.BData = b; bus.LoadValid = 1'b1;
      end
      @(negedge clk);
      bus.LoadValid = 1'b0; bus.AData = ~a; bus.BData = ~b;
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b1010) begin
         errors++;
         $display("FAIL start_cycle: got S/D/B/R=%b want 1010",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
      rx = '0; bad = 1'b0;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         rx[k] = bus.SerialData;
         if (bus.Start !== 1'b0 || bus.Busy !== 1'b1 || bus.LoadReady !== 1'b0) bad = 1'b1;
         bus.LoadValid = (k == glitch_k);
         bus.Done      = (k == done_k);
      end
      @(negedge clk);
      bus.LoadValid = 1'b0; bus.Done = 1'b0;
      checks++;
      if (rx !== exp_s) begin
         errors++;
         $display("FAIL stream: got %h want %h", rx, exp_s);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL shift_ctrl: Start/Busy/LoadReady wrong in SHIFT, want 0/1/0");
      end
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0010) begin
         errors++;
         $display("FAIL wait_entry: got S/D/B/R=%b want 0010",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0010) begin
         errors++;
         $display("FAIL wait_hold: got S/D/B/R=%b want 0010",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
      bus.Done = 1'b1;
      @(negedge clk);
      bus.Done = 1'b0;
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0001) begin
         errors++;
         $display("FAIL after_done: got S/D/B/R=%b want 0001",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
      if (chain) begin
         bus.AData = na; bus.BData = nb; bus.LoadValid = 1'b1;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_held: got S/D/B/R=%b want 0001",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
      Reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_release: got S/D/B/R=%b want 0001",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
   endtask

   task automatic test_ones_twos();
      logic [127:0] rx;
      run_frame({8{8'h01}}, {8{8'h02}}, -1, -1, 1'b0, 1'b0, '0, '0, rx);
      checks++;
      if (rx !== {8{16'h0201}}) begin
         errors++;
         $display("FAIL ones_twos_const: got %h want %h", rx, {8{16'h0201}});
      end
   endtask

   task automatic test_sparse();
      logic [127:0] rx;
      logic [127:0] want;
      want = '0; want[7:0] = 8'hFF; want[127] = 1'b1;
      run_frame(64'h0000_0000_0000_00FF, 64'h8000_0000_0000_0000, -1, -1,
                1'b0, 1'b0, '0, '0, rx);
      checks++;
      if (rx !== want) begin
         errors++;
         $display("FAIL sparse_bits: got %h want %h", rx, want);
      end
   endtask

   task automatic test_load_ignored();
      logic [127:0] rx;
      run_frame(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 50, -1,
                1'b0, 1'b0, '0, '0, rx);
   endtask

   task automatic test_back_to_back();
      logic [127:0] rx;
      logic [63:0]  a2, b2;
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      run_frame(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, -1, 10,
                1'b0, 1'b1, a2, b2, rx);
      run_frame(a2, b2, -1, -1, 1'b1, 1'b0, '0, '0, rx);
   endtask

   task automatic test_reset_mid();
      logic [127:0] rx;
      bit bad;
      checks++;
      if (bus.LoadReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ready: got %b want 1", bus.LoadReady);
      end
      bus.AData = '1; bus.BData = '1; bus.LoadValid = 1'b1;
      @(negedge clk);
      bus.LoadValid = 1'b0;
      repeat (65) @(negedge clk);
      checks++;
      if ({bus.SerialData, bus.Busy} !== 2'b11) begin
         errors++;
         $display("FAIL pre_abort: got D/B=%b want 11", {bus.SerialData, bus.Busy});
      end
      Reset = 1'b1;
      #1;
      checks++;
      if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0001) begin
         errors++;
         $display("FAIL abort_now: got S/D/B/R=%b want 0001",
                  {bus.Start, bus.SerialData, bus.Busy, bus.LoadReady});
      end
      @(negedge clk);
      Reset = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if ({bus.Start, bus.SerialData, bus.Busy, bus.LoadReady} !== 4'b0001) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_quiet: activity seen after abort, want S/D/B/R=0001");
      end
      run_frame({$urandom, $urandom}, {$urandom, $urandom}, -1, -1,
                1'b0, 1'b0, '0, '0, rx);
   endtask

   task automatic test_random();
      logic [127:0] rx;
      logic [63:0]  a, b;
      for (int n = 0; n < 4; n++) begin
         a = {$urandom, $urandom}; b = {$urandom, $urandom};
         run_frame(a, b, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                   1'b0, 1'b0, '0, '0, rx);
         checks++;
         if (rx_dot(rx) != model_dot(a, b)) begin
            errors++;
            $display("FAIL random_dot%0d: got %0d want %0d", n, rx_dot(rx), model_dot(a, b));
         end
      end
   endtask

   task automatic test_end_to_end();
      logic [127:0] rx;
      run_frame('1, '1, -1, -1, 1'b0, 1'b0, '0, '0, rx);
      checks++;
      if (rx_dot(rx) != 520200) begin
         errors++;
         $display("FAIL e2e_dot: got %0d want 520200", rx_dot(rx));
      end
   endtask

   initial begin
      Reset = 1'b1;
      bus.AData = '0; bus.BData = '0; bus.LoadValid = 1'b0; bus.Done = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_ones_twos();
      test_sparse();
      test_load_ignored();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_end_to_end();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
